// File: rtl/pb_pkg.sv
// Package: pb_pkg
// Shared state encoding and default timing constants for the pushbutton event path.
package pb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } pb_state_e;

    // Defaults assume a 50 MHz board clock and a 1 ms tick.
    localparam int unsigned PB_TICK_DIV_DEF  = 50000;
    localparam int unsigned PB_LONG_MS_DEF   = 1000;
    localparam int unsigned PB_REPEAT_MS_DEF = 200;
    localparam int unsigned PB_CNT_W_DEF     = 16;

endpackage

// File: rtl/pb_ms_tick.sv
// Module: pb_ms_tick
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// Shared by any block that needs coarse millisecond timing from clk.
module pb_ms_tick
    import pb_pkg::*;
#(
    parameter int unsigned TICK_DIV = PB_TICK_DIV_DEF,
    parameter int unsigned CNT_W    = PB_CNT_W_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    logic [CNT_W-1:0] r_div;
    logic             w_wrap;

    assign w_wrap = (r_div == CNT_W'(TICK_DIV - 1));

    // Divider counts 0..TICK_DIV-1 and wraps; never resynchronised to the button.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div <= '0;
        end else if (w_wrap) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + CNT_W'(1);
        end
    end

    assign o_tick = w_wrap;

endmodule

// File: rtl/pb_event_decoder.sv
// Module: pb_event_decoder
// Turns the debounced button level into one-clock press / release / long-press / repeat
// pulses plus a held level. Auto-repeat is built only when PB_AUTOREPEAT_EN is defined;
// otherwise the repeat output is tied low and LONG simply waits for the release.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | button up, or held through reset and not yet released
// ST_PRESSED | pressed, counting ticks toward LONG_MS
// ST_LONG    | long press reported; counting ticks toward each repeat
module pb_event_decoder
    import pb_pkg::*;
#(
    parameter int unsigned TICK_DIV  = PB_TICK_DIV_DEF,
    parameter int unsigned LONG_MS   = PB_LONG_MS_DEF,
    parameter int unsigned REPEAT_MS = PB_REPEAT_MS_DEF,
    parameter int unsigned CNT_W     = PB_CNT_W_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pb_level,
    output logic o_press,
    output logic o_release,
    output logic o_long_press,
    output logic o_repeat,
    output logic o_held
);

    // Counters never wrap, so both thresholds must fit in CNT_W and be non-zero.
    if (LONG_MS == 0 || (LONG_MS >> CNT_W) != 0 ||
        REPEAT_MS == 0 || (REPEAT_MS >> CNT_W) != 0) begin : g_param_err
        $error("pb_event_decoder: LONG_MS/REPEAT_MS must be in 1 .. 2**CNT_W-1");
    end

    logic             w_tick;
    logic             w_rise;
    logic             w_fall;
    logic             r_pb_prev;

    pb_state_e        r_state;
    pb_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_nxt;
    logic [CNT_W-1:0] w_hold_inc;

    logic             r_press;
    logic             r_release;
    logic             r_long_press;
    logic             r_held;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_long_nxt;

    pb_ms_tick #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_ms_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (w_tick)
    );

    assign w_rise     = i_pb_level & ~r_pb_prev;
    assign w_fall     = ~i_pb_level & r_pb_prev;
    assign w_hold_inc = r_hold_cnt + CNT_W'(1);

`ifdef PB_AUTOREPEAT_EN
    logic [CNT_W-1:0] r_rep_cnt;
    logic [CNT_W-1:0] w_rep_nxt;
    logic [CNT_W-1:0] w_rep_inc;
    logic             r_repeat;
    logic             w_repeat_nxt;

    assign w_rep_inc = r_rep_cnt + CNT_W'(1);
`endif

    // Next-state and next-output decode; a fall always beats a coincident tick.
    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
`ifdef PB_AUTOREPEAT_EN
        w_rep_nxt     = r_rep_cnt;
        w_repeat_nxt  = 1'b0;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_PRESSED;
                    w_press_nxt = 1'b1;
                    w_hold_nxt  = '0;
                end
            end
            ST_PRESSED: begin
                if (w_fall) begin
                    w_state_nxt   = ST_IDLE;
                    w_release_nxt = 1'b1;
                end else if (w_tick) begin
                    w_hold_nxt = w_hold_inc;
                    if (w_hold_inc == CNT_W'(LONG_MS)) begin
                        w_state_nxt = ST_LONG;
                        w_long_nxt  = 1'b1;
`ifdef PB_AUTOREPEAT_EN
                        w_rep_nxt   = '0;
`endif
                    end
                end
            end
            ST_LONG: begin
                if (w_fall) begin
                    w_state_nxt   = ST_IDLE;
                    w_release_nxt = 1'b1;
                end
`ifdef PB_AUTOREPEAT_EN
                else if (w_tick) begin
                    if (w_rep_inc == CNT_W'(REPEAT_MS)) begin
                        w_rep_nxt    = '0;
                        w_repeat_nxt = 1'b1;
                    end else begin
                        w_rep_nxt = w_rep_inc;
                    end
                end
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; pb_prev tracks the level even in reset
    // so a button held through reset is not reported as a press.
    always_ff @(posedge i_clk) begin
        r_pb_prev <= i_pb_level;
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_hold_cnt   <= '0;
            r_press      <= 1'b0;
            r_release    <= 1'b0;
            r_long_press <= 1'b0;
            r_held       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_press      <= w_press_nxt;
            r_release    <= w_release_nxt;
            r_long_press <= w_long_nxt;
            r_held       <= (w_state_nxt != ST_IDLE);
        end
    end

`ifdef PB_AUTOREPEAT_EN
    // Repeat counter and pulse register exist only in the auto-repeat build.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rep_cnt <= '0;
            r_repeat  <= 1'b0;
        end else begin
            r_rep_cnt <= w_rep_nxt;
            r_repeat  <= w_repeat_nxt;
        end
    end

    assign o_repeat = r_repeat;
`else
    assign o_repeat = 1'b0;
`endif

    assign o_press      = r_press;
    assign o_release    = r_release;
    assign o_long_press = r_long_press;
    assign o_held       = r_held;

endmodule

// File: tb/tb_pb_event_decoder.sv
// Testbench: tb_pb_event_decoder
// Drives pb_event_decoder with directed and random button levels and compares every cycle
// against a tick-counting reference model. Honours PB_AUTOREPEAT_EN like the design.
module tb_pb_event_decoder;

    localparam int TD = 4;
    localparam int LM = 5;
    localparam int RM = 3;
`ifdef PB_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pb_level = 1'b0;
    logic o_press, o_release, o_long_press, o_repeat, o_held;
    logic [4:0] obs;

    // reference model: pressed flag plus count of ticks seen since the press
    bit   m_prev, m_pressed;
    int   m_n, m_idx;
    logic [4:0] exp_vec;
    int   n_pass = 0;
    int   n_total = 0;

    assign obs = {o_press, o_release, o_long_press, o_repeat, o_held};

    pb_event_decoder #(
        .TICK_DIV  (TD),
        .LONG_MS   (LM),
        .REPEAT_MS (RM),
        .CNT_W     (16)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_pb_level   (pb_level),
        .o_press      (o_press),
        .o_release    (o_release),
        .o_long_press (o_long_press),
        .o_repeat     (o_repeat),
        .o_held       (o_held)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Apply one cycle of stimulus, advance the model, sample outputs 1 ns after the edge.
    task automatic cycle(input bit lvl, input bit rstv);
        bit tk, rise, fall, e_p, e_r, e_l, e_rp;
        @(negedge clk);
        rst = rstv;
        pb_level = lvl;
        e_p = 0; e_r = 0; e_l = 0; e_rp = 0;
        if (rstv) begin
            m_prev = lvl; m_pressed = 0; m_n = 0; m_idx = 0;
        end else begin
            tk   = (m_idx % TD) == TD - 1;
            rise = lvl && !m_prev;
            fall = !lvl && m_prev;
            if (m_pressed && fall) begin
                e_r = 1; m_pressed = 0;
            end else if (!m_pressed && rise) begin
                e_p = 1; m_pressed = 1; m_n = 0;
            end else if (m_pressed && tk) begin
                m_n++;
                e_l  = (m_n == LM);
                e_rp = AR && (m_n > LM) && ((m_n - LM) % RM == 0);
            end
            m_prev = lvl;
            m_idx++;
        end
        exp_vec = {e_p, e_r, e_l, e_rp, m_pressed};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
        n_total++;
        if (obs !== 5'b0) $display("FAIL reset_state: got %b expected 00000", obs);
        else n_pass++;
        cycle(1'b0, 1'b0);
        n_total++;
        if (obs !== exp_vec) $display("FAIL reset_release: got %b expected %b", obs, exp_vec);
        else n_pass++;
    endtask

    task automatic test_short_press();
        int n_press = 0, n_held = 0, n_lr = 0;
        for (int i = 0; i < 14; i++) begin
            cycle(i < 10, 1'b0);
            n_total++;
            if (obs !== exp_vec) $display("FAIL short_press cyc %0d: got %b expected %b", i, obs, exp_vec);
            else n_pass++;
            if (i == 0) begin
                n_total++;
                if (o_press !== 1'b1) $display("FAIL short_press_latency: press=%b expected 1", o_press);
                else n_pass++;
            end
            if (i == 10) begin
                n_total++;
                if (o_release !== 1'b1) $display("FAIL short_release_latency: release=%b expected 1", o_release);
                else n_pass++;
            end
            n_press += int'(o_press);
            n_held  += int'(o_held);
            n_lr    += int'(o_long_press) + int'(o_repeat);
        end
        n_total++;
        if (n_press != 1 || n_held != 10 || n_lr != 0)
            $display("FAIL short_press_summary: press=%0d held=%0d long+rep=%0d expected 1/10/0", n_press, n_held, n_lr);
        else n_pass++;
    endtask

    task automatic test_long_hold();
        int n_long = 0, n_rep = 0, e_rep = 0, t_long = -1, t_last = -1;
        for (int i = 0; i < 64; i++) begin
            cycle(i < 60, 1'b0);
            n_total++;
            if (obs !== exp_vec) $display("FAIL long_hold cyc %0d: got %b expected %b", i, obs, exp_vec);
            else n_pass++;
            e_rep += int'(exp_vec[1]);
            if (o_long_press === 1'b1) begin
                n_long++; t_long = i; t_last = i;
            end
            if (o_repeat === 1'b1) begin
                n_rep++;
                n_total++;
                if (i - t_last != RM * TD)
                    $display("FAIL repeat_spacing: got %0d cycles expected %0d", i - t_last, RM * TD);
                else n_pass++;
                t_last = i;
            end
        end
        n_total++;
        if (n_long != 1) $display("FAIL long_count: got %0d expected 1", n_long);
        else n_pass++;
        n_total++;
        if (t_long < LM * TD - TD + 1 || t_long > LM * TD)
            $display("FAIL long_latency: got %0d expected %0d..%0d", t_long, LM * TD - TD + 1, LM * TD);
        else n_pass++;
        n_total++;
        if (n_rep != e_rep || (!AR && n_rep != 0) || (AR && n_rep == 0))
            $display("FAIL repeat_count: got %0d expected %0d", n_rep, e_rep);
        else n_pass++;
    endtask

    task automatic test_fall_on_tick();
        bit found = 0;
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_n == LM - 1 && (m_idx % TD) == TD - 1) found = 1;
            else begin
                cycle(1'b1, 1'b0);
                n_total++;
                if (obs !== exp_vec) $display("FAIL fall_tick_hold cyc %0d: got %b expected %b", i, obs, exp_vec);
                else n_pass++;
            end
        end
        n_total++;
        if (!found) $display("FAIL fall_tick_setup: alignment not reached got 0 expected 1");
        else n_pass++;
        cycle(1'b0, 1'b0);
        n_total++;
        if (o_release !== 1'b1 || o_long_press !== 1'b0 || o_held !== 1'b0)
            $display("FAIL fall_on_tick: rel/long/held got %b%b%b expected 100", o_release, o_long_press, o_held);
        else n_pass++;
    endtask

    task automatic test_reset_held();
        int n_bad = 0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0);
            n_bad += int'(o_press) + int'(o_held);
        end
        n_total++;
        if (n_bad != 0) $display("FAIL reset_held_press: got %0d pulses/held expected 0", n_bad);
        else n_pass++;
        cycle(1'b0, 1'b0);
        n_total++;
        if (o_release !== 1'b0) $display("FAIL reset_held_release: got %b expected 0", o_release);
        else n_pass++;
        cycle(1'b1, 1'b0);
        n_total++;
        if (o_press !== 1'b1 || obs !== exp_vec) $display("FAIL reset_held_rise: got %b expected %b", obs, exp_vec);
        else n_pass++;
    endtask

    task automatic test_reset_in_long();
        int n_rel = 0;
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 40 && m_n < LM + 1; i++) cycle(1'b1, 1'b0);
        n_total++;
        if (o_held !== 1'b1 || m_n < LM) $display("FAIL long_setup: held=%b ticks=%0d expected 1/>=%0d", o_held, m_n, LM);
        else n_pass++;
        cycle(1'b1, 1'b1);
        n_total++;
        if (obs !== 5'b0) $display("FAIL reset_in_long: got %b expected 00000", obs);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            cycle(i < 3, 1'b0);
            n_rel += int'(o_release) + int'(o_press);
        end
        n_total++;
        if (n_rel != 0) $display("FAIL reset_in_long_after: got %0d pulses expected 0", n_rel);
        else n_pass++;
    endtask

    task automatic test_random();
        bit lvl = 0;
        int run;
        for (int blk = 0; blk < 40; blk++) begin
            lvl = ~lvl;
            run = $urandom_range(40, 1);
            for (int i = 0; i < run; i++) begin
                cycle(lvl, ($urandom_range(99, 0) == 0));
                n_total++;
                if (obs !== exp_vec) $display("FAIL random blk %0d cyc %0d: got %b expected %b", blk, i, obs, exp_vec);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_long_hold();
        test_fall_on_tick();
        test_reset_held();
        test_reset_in_long();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
